// File: rtl/gcd_output.sv
// Result-collection stage of the Euclidean GCD datapath: captures |A| and the iteration count on B == 0.
// Optional macro GCD_OUTPUT_ZERO_ERR_EN flags termination with A == B == 0 as an error.
module gcd_output #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned CNT_WIDTH      = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         Start,
   input  logic signed [DATA_WIDTH-1:0] Ain,
   input  logic signed [DATA_WIDTH-1:0] Bin,
   input  logic        [DATA_WIDTH-1:0] Cin,
   input  logic                         Ready,
   output logic        [DATA_WIDTH-1:0] Result,
   output logic        [CNT_WIDTH-1:0]  Iters,
   output logic                         Valid,
   output logic                         Error,
   output logic                         Busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                  state, state_n;
   logic [CNT_WIDTH-1:0]    wd, wd_n;
   logic [DATA_WIDTH-1:0]   result_n;
   logic [CNT_WIDTH-1:0]    iters_n;
   logic                    valid_n, error_n, busy_n;
   logic [DATA_WIDTH-1:0]   a_u, mag;

   // Two's-complement magnitude; the most negative value maps to 2^(DATA_WIDTH-1).
   always_comb begin
      a_u = Ain;
      mag = a_u[DATA_WIDTH-1] ? ((~a_u) + DATA_WIDTH'(1)) : a_u;
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state  <= IDLE;
         wd     <= '0;
         Result <= '0;
         Iters  <= '0;
         Valid  <= 1'b0;
         Error  <= 1'b0;
         Busy   <= 1'b0;
      end else begin
         state  <= state_n;
         wd     <= wd_n;
         Result <= result_n;
         Iters  <= iters_n;
         Valid  <= valid_n;
         Error  <= error_n;
         Busy   <= busy_n;
      end
   end

   always_comb begin
      state_n  = state;
      wd_n     = wd;
      result_n = Result;
      iters_n  = Iters;
      valid_n  = Valid;
      error_n  = Error;
      case (state)
         IDLE: begin
            if (Start) begin
               state_n = WAIT;
               wd_n    = '0;
            end
         end
         WAIT: begin
            if (Start) begin
               wd_n = '0;
            end else if (Bin == '0) begin
               result_n = mag;
               iters_n  = CNT_WIDTH'(Cin);
               valid_n  = 1'b1;
`ifdef GCD_OUTPUT_ZERO_ERR_EN
               error_n  = (Ain == '0);
`else
               error_n  = 1'b0;
`endif
               state_n  = HOLD;
            end else if (wd == WD_LAST) begin
               result_n = '0;
               iters_n  = wd;
               valid_n  = 1'b1;
               error_n  = 1'b1;
               state_n  = HOLD;
            end else begin
               wd_n = wd + CNT_WIDTH'(1);
            end
         end
         HOLD: begin
            // Start without Ready is a protocol violation and is ignored.
            if (Ready) begin
               valid_n = 1'b0;
               error_n = 1'b0;
               if (Start) begin
                  state_n = WAIT;
                  wd_n    = '0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_gcd_output.sv
// Directed self-checking bench for gcd_output (TIMEOUT_CYCLES overridden to 8).
module tb_gcd_output;

   logic               Clk;
   logic               Reset;
   logic               Start;
   logic signed [31:0] Ain;
   logic signed [31:0] Bin;
   logic        [31:0] Cin;
   logic               Ready;
   logic        [31:0] Result;
   logic        [15:0] Iters;
   logic               Valid;
   logic               Error;
   logic               Busy;

   int unsigned total = 0;
   int unsigned bad   = 0;

   gcd_output #(
      .DATA_WIDTH(32),
      .CNT_WIDTH(16),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .Start(Start),
      .Ain(Ain),
      .Bin(Bin),
      .Cin(Cin),
      .Ready(Ready),
      .Result(Result),
      .Iters(Iters),
      .Valid(Valid),
      .Error(Error),
      .Busy(Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      Reset = 1'b0; Start = 1'b0; Ain = '0; Bin = '0; Cin = '0; Ready = 1'b0;
      #12;
      chk("rst_result", Result, 32'd0);
      chk("rst_iters",  {16'd0, Iters}, 32'd0);
      chk("rst_valid",  {31'd0, Valid}, 32'd0);
      chk("rst_error",  {31'd0, Error}, 32'd0);
      chk("rst_busy",   {31'd0, Busy},  32'd0);
      Reset = 1'b1;
      step();

      // Basic capture and hold
      Start = 1'b1; Bin = 32'sd9;
      step();
      chk("arm_busy",  {31'd0, Busy},  32'd1);
      chk("arm_valid", {31'd0, Valid}, 32'd0);
      Start = 1'b0; Ain = 32'sd48; Bin = 32'sd0; Cin = 32'd3;
      step();
      chk("cap_valid",  {31'd0, Valid}, 32'd1);
      chk("cap_result", Result, 32'd48);
      chk("cap_iters",  {16'd0, Iters}, 32'd3);
      chk("cap_error",  {31'd0, Error}, 32'd0);
      chk("cap_busy",   {31'd0, Busy},  32'd1);
      Ain = 32'sd77; Cin = 32'd9;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_valid",  {31'd0, Valid}, 32'd1);
         chk("hold_result", Result, 32'd48);
         chk("hold_iters",  {16'd0, Iters}, 32'd3);
      end
      Ready = 1'b1;
      step();
      chk("ack_valid",  {31'd0, Valid}, 32'd0);
      chk("ack_busy",   {31'd0, Busy},  32'd0);
      chk("ack_result", Result, 32'd48);
      Ready = 1'b0;

      // Bin==0 during the Start cycle must not capture
      Start = 1'b1; Ain = 32'sd10; Bin = 32'sd0; Cin = 32'd0;
      step();
      chk("load_nocap", {31'd0, Valid}, 32'd0);
      Start = 1'b0; Bin = 32'sd5;
      step();
      chk("b5_nocap", {31'd0, Valid}, 32'd0);
      Ain = -32'sd21; Bin = 32'sd0; Cin = 32'd2;
      step();
      chk("neg_valid",  {31'd0, Valid}, 32'd1);
      chk("neg_result", Result, 32'd21);
      chk("neg_iters",  {16'd0, Iters}, 32'd2);
      Ready = 1'b1;
      step();
      Ready = 1'b0;

      // Most negative operand
      Start = 1'b1; Bin = 32'sd1;
      step();
      Start = 1'b0; Ain = 32'sh8000_0000; Bin = 32'sd0; Cin = 32'd0;
      step();
      chk("min_result", Result, 32'h8000_0000);
      chk("min_error",  {31'd0, Error}, 32'd0);
      Ready = 1'b1;
      step();
      Ready = 1'b0;

      // Watchdog timeout: Start sampled at edge 0, timeout captured at edge 8
      Start = 1'b1; Bin = 32'sd7; Ain = 32'sd14; Cin = 32'd100;
      step();
      Start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         step();
         chk("to_wait_valid", {31'd0, Valid}, 32'd0);
      end
      step();
      chk("to_valid",  {31'd0, Valid}, 32'd1);
      chk("to_error",  {31'd0, Error}, 32'd1);
      chk("to_result", Result, 32'd0);
      chk("to_iters",  {16'd0, Iters}, 32'd7);

      // Ready and Start together in HOLD re-arm
      Ready = 1'b1; Start = 1'b1;
      step();
      chk("rearm_valid", {31'd0, Valid}, 32'd0);
      chk("rearm_busy",  {31'd0, Busy},  32'd1);
      Ready = 1'b0; Start = 1'b0; Ain = 32'sd9; Bin = 32'sd0; Cin = 32'd4;
      step();
      chk("rearm_valid2", {31'd0, Valid}, 32'd1);
      chk("rearm_result", Result, 32'd9);
      chk("rearm_iters",  {16'd0, Iters}, 32'd4);
      chk("rearm_error",  {31'd0, Error}, 32'd0);
      Ready = 1'b1;
      step();
      Ready = 1'b0;

      // Asynchronous reset while in WAIT
      Start = 1'b1; Bin = 32'sd3;
      step();
      Start = 1'b0;
      step();
      chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
      #2 Reset = 1'b0;
      #1;
      chk("arst_result", Result, 32'd0);
      chk("arst_iters",  {16'd0, Iters}, 32'd0);
      chk("arst_valid",  {31'd0, Valid}, 32'd0);
      chk("arst_busy",   {31'd0, Busy},  32'd0);
      Reset = 1'b1;
      Bin = 32'sd0; Ain = 32'sd5;
      step();
      chk("post_rst_idle_valid", {31'd0, Valid}, 32'd0);
      chk("post_rst_idle_busy",  {31'd0, Busy},  32'd0);

      // Both operands zero
      Start = 1'b1; Bin = 32'sd2;
      step();
      Start = 1'b0; Ain = 32'sd0; Bin = 32'sd0; Cin = 32'd0;
      step();
      chk("zero_valid",  {31'd0, Valid}, 32'd1);
      chk("zero_result", Result, 32'd0);
`ifdef GCD_OUTPUT_ZERO_ERR_EN
      chk("zero_error", {31'd0, Error}, 32'd1);
`else
      chk("zero_error", {31'd0, Error}, 32'd0);
`endif
      Ready = 1'b1;
      step();
      chk("zero_ack_busy", {31'd0, Busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
